dut_scan_ctrl: RTL

Scan-chain controller that sits directly upstream of the IAS datapath scan port and drives its `sen`, `scan_ce` and `sin`, while consuming its `sout`. It accepts one read or write command at a time from a valid/ready command channel and shifts the full chain once. It returns the captured chain contents on a valid/ready response channel. While a shift is in progress it asserts `func_stall` so that functional register enables are held off.

---
 rtl/dut_scan_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/dut_scan_ctrl.sv
// dut_scan_ctrl: scan-chain controller that runs one full-chain read (loopback) or write (swap) per command.
// Optional feature macro: DUT_SCAN_PAUSE_EN adds a scan_pause input that freezes shifting mid-command.
module dut_scan_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [CHAIN_LEN-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_rdata,
    output logic                 scan_sen,
    output logic                 scan_ce,
    output logic                 scan_sin,
    input  logic                 scan_sout,
`ifdef DUT_SCAN_PAUSE_EN
    input  logic                 scan_pause,
`endif
    output logic                 func_stall
);
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    state_t               state, state_nxt;
    logic                 op_write;
    logic [CHAIN_LEN-1:0] wsh, cap;
    logic [CNT_W-1:0]     cnt;
    logic                 pause, accept, shift_en;
`ifdef DUT_SCAN_PAUSE_EN
    assign pause = scan_pause;
`else
    assign pause = 1'b0;
`endif
    // next-state and state-decoded outputs; scan_sin loops sout back on reads so the chain is restored
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        scan_sen   = 1'b0;
        scan_ce    = 1'b0;
        scan_sin   = 1'b0;
        func_stall = 1'b0;
        accept     = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                state_nxt = cmd_valid ? SHIFT : IDLE;
            end
            SHIFT: begin
                scan_sen   = 1'b1;
                func_stall = 1'b1;
                scan_ce    = ~pause;
                shift_en   = ~pause && cnt != '0;
                scan_sin   = op_write ? wsh[0] : scan_sout;
                state_nxt  = (shift_en && cnt == CNT_W'(1)) ? RESP : SHIFT;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = cap;
                state_nxt = rsp_ready ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    // command latch, capture shift (first sout bit ends in bit 0), write-data shift and bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_write <= 1'b0;
            wsh      <= '0;
            cap      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            op_write <= cmd_write;
            wsh      <= cmd_wdata;
            cap      <= '0;
            cnt      <= CNT_W'(CHAIN_LEN);
        end else if (shift_en) begin
            cap <= {scan_sout, cap[CHAIN_LEN-1:1]};
            wsh <= wsh >> 1;
            cnt <= cnt - 1'b1;
        end
    end
endmodule
